lock_chamber_ctrl: RTL and testbench
====================================

# lock_chamber_ctrl

Chamber sequencer that consumes the registered `arriveSignal` / `departSignal` requests from the arrive/depart signal stage. It runs the door and pressure sequence for one vehicle crossing. It drives the door and pump outputs and reports occupancy on `EVState`, which feeds back into the arrive/depart stage to gate new requests. Phase durations are cycle counts set by parameters.

## Interface
- `DOOR_CYCLES`, default 4: cycles a door stays open per phase; legal range 1..255.
- `PRESS_CYCLES`, default 8: cycles to pressurize or depressurize the chamber; legal range 1..255.
- `clk` in 1: system clock. All state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `arriveSignal` in 1: arrival request, level. Sampled only in `EMPTY`.
- `departSignal` in 1: departure request, level. Sampled only in `DOCKED`.
- `outerOpen` out 1: outer (vacuum-side) door open.
- `innerOpen` out 1: inner (habitat-side) door open.
- `pressurizing` out 1: pump filling the chamber.
- `depressurizing` out 1: pump evacuating the chamber.
- `EVState` out 1: 1 = vehicle docked inside and chamber pressurized; 0 = chamber empty at vacuum.
- `busy` out 1: high in every state except `EMPTY` and `DOCKED`.
- `timeLeft` out 8: remaining cycles in the current timed phase, including the current cycle. Reads 0 in idle states.

## Operation
- There are 8 states, held in one state register plus an 8-bit down-counter `cnt`.
- States: `EMPTY`, `ARR_OUTER`, `ARR_PRESS`, `ARR_INNER`, `DOCKED`, `DEP_INNER`, `DEP_DEPRESS`, `DEP_OUTER`.
- Transitions:
  - `EMPTY` goes to `ARR_OUTER` when `arriveSignal` is 1 and `departSignal` is 0.
  - `ARR_OUTER` goes to `ARR_PRESS`, then to `ARR_INNER`, then to `DOCKED`. Each step fires when `cnt` is 0.
  - `DOCKED` goes to `DEP_INNER` when `departSignal` is 1 and `arriveSignal` is 0.
  - `DEP_INNER` goes to `DEP_DEPRESS`, then to `DEP_OUTER`, then to `EMPTY`. Each step fires when `cnt` is 0.
- Counter:
  - On entry to a timed phase, `cnt` loads its phase length minus 1: `DOOR_CYCLES`-1 for door phases, `PRESS_CYCLES`-1 for pressure phases.
  - `cnt` decrements each cycle while nonzero.
  - A phase therefore lasts exactly its parameter value in cycles.
- Output decode, from the state register only (no input-to-output combinational path):
  - `outerOpen` = `ARR_OUTER` | `DEP_OUTER`
  - `innerOpen` = `ARR_INNER` | `DEP_INNER`
  - `pressurizing` = `ARR_PRESS`
  - `depressurizing` = `DEP_DEPRESS`
  - `EVState` = `DOCKED` | `DEP_INNER` | `DEP_DEPRESS` | `DEP_OUTER`
  - `timeLeft` = `cnt` + 1 in timed states, 0 otherwise.
- Interlocks:
  - `outerOpen` and `innerOpen` are never both 1.
  - No door is open while either pump output is 1.
  - `pressurizing` and `depressurizing` are never both 1.
- Requests during `busy` are ignored; there is no queuing.
- `arriveSignal` is ignored in `DOCKED`; `departSignal` is ignored in `EMPTY`.
- Both requests high at once: no action, state holds.
- A request still held high after its sequence completes does not retrigger. An arrive request is not legal in `DOCKED`, and a depart request is not legal in `EMPTY`.

## Timing
- Reset: `rst` = 0 sampled at a rising edge gives the following on the next cycle:
  - state `EMPTY`, `cnt` = 0;
  - all outputs 0, including `EVState` = 0 and `timeLeft` = 0.
- Reset mid-sequence aborts immediately with the same values. Doors close and pumps stop on that edge.
- Request latency: a request sampled at edge N puts the block in the first phase from edge N, so the door output is high in cycle N+1.
- Arrival sequence (defaults):
  - `outerOpen` high for 4 cycles;
  - then `pressurizing` high for 8 cycles;
  - then `innerOpen` high for 4 cycles;
  - `EVState` rises on the edge that follows.
  - Total 2·`DOOR_CYCLES`+`PRESS_CYCLES` = 16 cycles from acceptance to `DOCKED`.
- Departure sequence: symmetric, also 16 cycles. `EVState` falls on the edge entering `EMPTY`.
- Back-to-back phases have no gap cycle. The next phase output rises on the same edge the previous one falls.
- With `DOOR_CYCLES` = 1, each door is open for exactly one cycle.

## Test plan
- Apply reset for 2 cycles, then release. All outputs must read 0 and `busy` must be 0.
- Pulse `arriveSignal` for 1 cycle (defaults). Required response:
  - `outerOpen` high in cycles 1-4, `pressurizing` high in cycles 5-12, `innerOpen` high in cycles 13-16;
  - `EVState` = 1 from cycle 17;
  - `timeLeft` reads 4,3,2,1 then 8..1 then 4..1.
- From `DOCKED`, hold `departSignal` high for 30 cycles. Required response:
  - `innerOpen` high in cycles 1-4, `depressurizing` high in cycles 5-12, `outerOpen` high in cycles 13-16;
  - `EVState` = 0 from cycle 17;
  - no retrigger afterwards.
- During `ARR_PRESS`, assert `departSignal` and re-assert `arriveSignal`. The sequence timing must be unchanged.
- In `EMPTY`, assert `arriveSignal` = `departSignal` = 1 for 5 cycles. The state stays `EMPTY` and all outputs stay 0.
- Assert `rst` = 0 at cycle 6 of an arrival. On the next cycle all outputs must be 0 and the state `EMPTY`. A new `arriveSignal` must then restart the full 16-cycle sequence.

Source files
------------

// File: rtl/lock_chamber_if.sv
// Request/response bundle between the arrive/depart stage (master) and the chamber sequencer (slave).
// Requests are levels; all sequencer outputs are decoded from registered state.
interface lock_chamber_if;
    logic       arriveSignal;
    logic       departSignal;
    logic       outerOpen;
    logic       innerOpen;
    logic       pressurizing;
    logic       depressurizing;
    logic       EVState;
    logic       busy;
    logic [7:0] timeLeft;

    modport master (
        output arriveSignal, departSignal,
        input  outerOpen, innerOpen, pressurizing, depressurizing, EVState, busy, timeLeft
    );

    modport slave (
        input  arriveSignal, departSignal,
        output outerOpen, innerOpen, pressurizing, depressurizing, EVState, busy, timeLeft
    );
endinterface

// File: rtl/lock_chamber_ctrl.sv
// Airlock door/pump sequencer: a request accepted at edge N opens the first door in cycle N+1; each phase lasts its parameter in cycles.
// No backpressure: requests arriving while busy, or both requests at once, are dropped rather than queued.
module lock_chamber_ctrl #(
    parameter int unsigned DOOR_CYCLES  = 4,
    parameter int unsigned PRESS_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst,
    lock_chamber_if.slave  lc
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_ARR_OUTER,
        S_ARR_PRESS,
        S_ARR_INNER,
        S_DOCKED,
        S_DEP_INNER,
        S_DEP_DEPRESS,
        S_DEP_OUTER
    } state_t;

    localparam logic [7:0] DOOR_LOAD  = 8'(DOOR_CYCLES - 1);
    localparam logic [7:0] PRESS_LOAD = 8'(PRESS_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    state_t     w_nxt_state;
    logic [7:0] w_nxt_cnt;
    logic       w_cnt_zero;
    logic       w_timed;

    assign w_cnt_zero = (r_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = w_cnt_zero ? r_cnt : r_cnt - 8'd1;
        case (r_state)
            S_EMPTY: begin
                if (lc.arriveSignal && !lc.departSignal) begin
                    w_nxt_state = S_ARR_OUTER;
                    w_nxt_cnt   = DOOR_LOAD;
                end
            end
            S_ARR_OUTER: begin
                if (w_cnt_zero) begin
                    w_nxt_state = S_ARR_PRESS;
                    w_nxt_cnt   = PRESS_LOAD;
                end
            end
            S_ARR_PRESS: begin
                if (w_cnt_zero) begin
                    w_nxt_state = S_ARR_INNER;
                    w_nxt_cnt   = DOOR_LOAD;
                end
            end
            S_ARR_INNER: begin
                if (w_cnt_zero) w_nxt_state = S_DOCKED;
            end
            S_DOCKED: begin
                if (lc.departSignal && !lc.arriveSignal) begin
                    w_nxt_state = S_DEP_INNER;
                    w_nxt_cnt   = DOOR_LOAD;
                end
            end
            S_DEP_INNER: begin
                if (w_cnt_zero) begin
                    w_nxt_state = S_DEP_DEPRESS;
                    w_nxt_cnt   = PRESS_LOAD;
                end
            end
            S_DEP_DEPRESS: begin
                if (w_cnt_zero) begin
                    w_nxt_state = S_DEP_OUTER;
                    w_nxt_cnt   = DOOR_LOAD;
                end
            end
            S_DEP_OUTER: begin
                if (w_cnt_zero) w_nxt_state = S_EMPTY;
            end
            default: begin
                w_nxt_state = S_EMPTY;
                w_nxt_cnt   = 8'd0;
            end
        endcase
    end

    // Pure state decode keeps the door/pump interlocks structural: only one state is ever active.
    assign w_timed           = (r_state != S_EMPTY) && (r_state != S_DOCKED);
    assign lc.outerOpen      = (r_state == S_ARR_OUTER) || (r_state == S_DEP_OUTER);
    assign lc.innerOpen      = (r_state == S_ARR_INNER) || (r_state == S_DEP_INNER);
    assign lc.pressurizing   = (r_state == S_ARR_PRESS);
    assign lc.depressurizing = (r_state == S_DEP_DEPRESS);
    assign lc.EVState        = (r_state == S_DOCKED)    || (r_state == S_DEP_INNER) ||
                               (r_state == S_DEP_DEPRESS) || (r_state == S_DEP_OUTER);
    assign lc.busy           = w_timed;
    assign lc.timeLeft       = w_timed ? r_cnt + 8'd1 : 8'd0;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Bench for lock_chamber_ctrl: default timing instance plus a DOOR_CYCLES=1 instance, both against a cycle-position model.
module tb_lock_chamber_ctrl;
    localparam int DA = 4, PA = 8;
    localparam int DB = 1, PB = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic arr = 1'b0;
    logic dep = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int   m_t[2];
    bit   m_docked[2];

    lock_chamber_if ifa ();
    lock_chamber_if ifb ();

    assign ifa.arriveSignal = arr;
    assign ifa.departSignal = dep;
    assign ifb.arriveSignal = arr;
    assign ifb.departSignal = dep;

    lock_chamber_ctrl #(.DOOR_CYCLES(DA), .PRESS_CYCLES(PA)) u_dut_a (.clk(clk), .rst(rst), .lc(ifa));
    lock_chamber_ctrl #(.DOOR_CYCLES(DB), .PRESS_CYCLES(PB)) u_dut_b (.clk(clk), .rst(rst), .lc(ifb));

    always #5 clk = ~clk;

    function automatic int dcyc(input int k);
        return (k == 0) ? DA : DB;
    endfunction

    function automatic int pcyc(input int k);
        return (k == 0) ? PA : PB;
    endfunction

    // Model: position t (1-based) inside a crossing, 0 when idle; docked flips when a crossing completes.
    function automatic logic [13:0] exp_vec(input int k);
        int d, p, t;
        bit dk;
        logic o, i, pr, dp;
        logic [7:0] tl;
        d = dcyc(k); p = pcyc(k); t = m_t[k]; dk = m_docked[k];
        o = 1'b0; i = 1'b0; pr = 1'b0; dp = 1'b0; tl = 8'd0;
        if (t != 0) begin
            if (t <= d) begin
                tl = 8'(d - t + 1);
                if (dk) i = 1'b1; else o = 1'b1;
            end else if (t <= d + p) begin
                tl = 8'(d + p - t + 1);
                if (dk) dp = 1'b1; else pr = 1'b1;
            end else begin
                tl = 8'(2 * d + p - t + 1);
                if (dk) o = 1'b1; else i = 1'b1;
            end
        end
        return {o, i, pr, dp, dk, (t != 0), tl};
    endfunction

    function automatic logic [13:0] got_vec(input int k);
        if (k == 0)
            return {ifa.outerOpen, ifa.innerOpen, ifa.pressurizing, ifa.depressurizing,
                    ifa.EVState, ifa.busy, ifa.timeLeft};
        return {ifb.outerOpen, ifb.innerOpen, ifb.pressurizing, ifb.depressurizing,
                ifb.EVState, ifb.busy, ifb.timeLeft};
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_t[k] = 0;
                m_docked[k] = 1'b0;
            end else if (m_t[k] != 0) begin
                if (m_t[k] == 2 * dcyc(k) + pcyc(k)) begin
                    m_t[k] = 0;
                    m_docked[k] = !m_docked[k];
                end else begin
                    m_t[k] = m_t[k] + 1;
                end
            end else if (!m_docked[k] && arr && !dep) begin
                m_t[k] = 1;
            end else if (m_docked[k] && dep && !arr) begin
                m_t[k] = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; arr = 1'b0; dep = 1'b0;
        tick(); tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_vec(k) !== 14'h0) begin
                errors++;
                $display("FAIL reset_state inst%0d got=%h exp=%h", k, got_vec(k), 14'h0);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL reset_idle inst%0d got=%h exp=%h", k, got_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_arrival();
        int n_out = 0, n_prs = 0, n_inn = 0, ev_first = 0;
        arr = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            arr = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL arrival inst%0d cyc%0d got=%h exp=%h", k, c, got_vec(k), exp_vec(k));
                end
            end
            n_out += int'(ifa.outerOpen);
            n_prs += int'(ifa.pressurizing);
            n_inn += int'(ifa.innerOpen);
            if (ifa.EVState && ev_first == 0) ev_first = c;
        end
        checks++;
        if (n_out != DA || n_prs != PA || n_inn != DA) begin
            errors++;
            $display("FAIL arrival_phase_len got=%0d/%0d/%0d exp=%0d/%0d/%0d", n_out, n_prs, n_inn, DA, PA, DA);
        end
        checks++;
        if (ev_first != 17) begin
            errors++;
            $display("FAIL arrival_ev_rise got=%0d exp=17", ev_first);
        end
    endtask

    task automatic test_departure();
        int n_busy = 0, n_dep = 0, ev_fall = 0;
        dep = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL departure inst%0d cyc%0d got=%h exp=%h", k, c, got_vec(k), exp_vec(k));
                end
            end
            n_busy += int'(ifa.busy);
            n_dep  += int'(ifa.depressurizing);
            if (!ifa.EVState && ev_fall == 0) ev_fall = c;
        end
        dep = 1'b0;
        checks++;
        if (n_busy != 16 || n_dep != PA) begin
            errors++;
            $display("FAIL departure_len busy got=%0d exp=16 depress got=%0d exp=%0d", n_busy, n_dep, PA);
        end
        checks++;
        if (ev_fall != 17) begin
            errors++;
            $display("FAIL departure_ev_fall got=%0d exp=17", ev_fall);
        end
    endtask

    task automatic test_ignore_busy();
        int ev_first = 0;
        arr = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c >= 4 && c <= 11) begin
                arr = 1'($urandom_range(0, 1));
                dep = 1'($urandom_range(0, 1));
            end else begin
                arr = 1'b0;
                dep = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL ignore_busy inst%0d cyc%0d got=%h exp=%h", k, c, got_vec(k), exp_vec(k));
                end
            end
            if (ifa.EVState && ev_first == 0) ev_first = c;
        end
        checks++;
        if (ev_first != 17) begin
            errors++;
            $display("FAIL ignore_busy_timing got=%0d exp=17", ev_first);
        end
        dep = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            dep = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL return_empty inst%0d cyc%0d got=%h exp=%h", k, c, got_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_both_high();
        arr = 1'b1; dep = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== 14'h0) begin
                    errors++;
                    $display("FAIL both_high inst%0d cyc%0d got=%h exp=%h", k, c, got_vec(k), 14'h0);
                end
            end
        end
        arr = 1'b0; dep = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n_busy = 0, ev_first = 0;
        arr = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            arr = 1'b0;
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_vec(k) !== 14'h0) begin
                errors++;
                $display("FAIL reset_mid inst%0d got=%h exp=%h", k, got_vec(k), 14'h0);
            end
        end
        arr = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            arr = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL restart inst%0d cyc%0d got=%h exp=%h", k, c, got_vec(k), exp_vec(k));
                end
            end
            n_busy += int'(ifa.busy);
            if (ifa.EVState && ev_first == 0) ev_first = c;
        end
        checks++;
        if (n_busy != 16 || ev_first != 17) begin
            errors++;
            $display("FAIL restart_len busy got=%0d exp=16 ev got=%0d exp=17", n_busy, ev_first);
        end
    endtask

    task automatic test_random();
        for (int c = 1; c <= 600; c++) begin
            arr = ($urandom_range(0, 3) == 0);
            dep = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 59) != 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                logic [13:0] g;
                g = got_vec(k);
                checks++;
                if (g !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d got=%h exp=%h", k, c, g, exp_vec(k));
                end
                checks++;
                if ((g[13] && g[12]) || ((g[13] || g[12]) && (g[11] || g[10])) || (g[11] && g[10])) begin
                    errors++;
                    $display("FAIL interlock inst%0d cyc%0d got=%b exp=no_overlap", k, c, g[13:10]);
                end
            end
        end
        rst = 1'b1; arr = 1'b0; dep = 1'b0;
    endtask

    initial begin
        m_t[0] = 0; m_t[1] = 0;
        m_docked[0] = 1'b0; m_docked[1] = 1'b0;
        test_reset();
        test_arrival();
        test_departure();
        test_ignore_busy();
        test_both_high();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
